// File: rtl/mvu_job_scheduler.sv
// In-order job queue that dispatches each head job to one idle, eligible MVU unit,
// picked round-robin, and tracks per-unit busy state, completions and error flags.
module mvu_job_scheduler #(
    parameter int N_MVU      = 8,
    parameter int JOB_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [JOB_W-1:0]                job_data,
    input  logic [N_MVU-1:0]                job_mask,
    output logic [N_MVU-1:0]                mvu_start,
    output logic [JOB_W-1:0]                mvu_cmd,
    input  logic [N_MVU-1:0]                mvu_done,
    output logic [N_MVU-1:0]                busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     done_count,
    output logic                            idle,
    output logic                            err_done,
    output logic                            err_mask,
    input  logic                            err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(N_MVU);

    // The head entry has to be visible in the same cycle it is arbitrated, so the
    // queue storage is read asynchronously (small enough for distributed RAM).
    logic [JOB_W-1:0] data_mem [FIFO_DEPTH];
    logic [N_MVU-1:0] mask_mem [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic [N_MVU-1:0] busy_reg, busy_next;
    logic [N_MVU-1:0] start_reg, start_next;
    logic [JOB_W-1:0] cmd_reg, cmd_next;
    logic [GW-1:0]    last_grant_reg, last_grant_next;
    logic [15:0]      done_count_reg, done_count_next;
    logic             err_done_reg, err_done_next;
    logic             err_mask_reg, err_mask_next;

    logic             push, pop, nonempty, dispatch, drop_head, found;
    logic [JOB_W-1:0] head_data;
    logic [N_MVU-1:0] head_mask, eligible, start_onehot, done_hit, done_stray;
    logic [GW-1:0]    winner;
    logic [15:0]      done_inc;

    assign nonempty  = (count_reg != '0);
    assign job_ready = (count_reg < CW'(FIFO_DEPTH));
    assign push      = job_valid && job_ready;
    assign head_data = data_mem[rd_ptr_reg];
    assign head_mask = mask_mem[rd_ptr_reg];
    assign eligible  = nonempty ? (head_mask & ~busy_reg) : '0;
    assign drop_head = nonempty && (head_mask == '0);
    assign dispatch  = (eligible != '0);
    assign pop       = dispatch || drop_head;

    // Round-robin: first eligible unit at or after last_grant+1, wrapping upward.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_MVU; k++) begin
            if (!found && eligible[(int'(last_grant_reg) + 1 + k) % N_MVU]) begin
                found  = 1'b1;
                winner = GW'((int'(last_grant_reg) + 1 + k) % N_MVU);
            end
        end
    end

    assign done_hit   = mvu_done & busy_reg;
    assign done_stray = mvu_done & ~busy_reg;

    generate
        for (genvar gi = 0; gi < N_MVU; gi++) begin : g_unit
            assign start_onehot[gi] = (winner == GW'(gi));
            assign busy_next[gi]    = (busy_reg[gi] & ~mvu_done[gi]) | (dispatch & start_onehot[gi]);
        end
    endgenerate

    always_comb begin
        done_inc = '0;
        for (int i = 0; i < N_MVU; i++) begin
            done_inc = done_inc + 16'(done_hit[i]);
        end
    end

    always_comb begin
        count_next      = count_reg;
        start_next      = '0;
        cmd_next        = cmd_reg;
        last_grant_next = last_grant_reg;
        done_count_next = done_count_reg + done_inc;
        err_done_next   = err_done_reg | (done_stray != '0);
        err_mask_next   = err_mask_reg | drop_head;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (dispatch) begin
            start_next      = start_onehot;
            cmd_next        = head_data;
            last_grant_next = winner;
        end
        if (err_clr) begin
            err_done_next = 1'b0;
            err_mask_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= job_data;
            mask_mem[wr_ptr_reg] <= job_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            busy_reg       <= '0;
            start_reg      <= '0;
            cmd_reg        <= '0;
            last_grant_reg <= GW'(N_MVU - 1);
            done_count_reg <= '0;
            err_done_reg   <= 1'b0;
            err_mask_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg      <= count_next;
            busy_reg       <= busy_next;
            start_reg      <= start_next;
            cmd_reg        <= cmd_next;
            last_grant_reg <= last_grant_next;
            done_count_reg <= done_count_next;
            err_done_reg   <= err_done_next;
            err_mask_reg   <= err_mask_next;
        end
    end

    assign mvu_start  = start_reg;
    assign mvu_cmd    = cmd_reg;
    assign busy       = busy_reg;
    assign fifo_count = count_reg;
    assign done_count = done_count_reg;
    assign err_done   = err_done_reg;
    assign err_mask   = err_mask_reg;
    assign idle       = !nonempty && (busy_reg == '0) && (start_reg == '0);

endmodule
